conv1_sequencer: RTL

CONV1_SEQUENCER -- requirements
Module: conv1_sequencer

---
 rtl/conv1_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/conv1_sequencer.sv
// Layer-1 convolution sequencer: slides a 5-tap window over one ECG frame,
// drives the conv datapath for CONV_LAT cycles per window and streams packed results.
module conv1_sequencer #(
  parameter int unsigned N_SAMPLES = 186,
  parameter int unsigned CONV_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        conv_en,
  output logic [39:0] conv_win,
  input  logic [7:0]  conv_r1,
  input  logic [7:0]  conv_r2,
  input  logic [7:0]  conv_r3,
  input  logic [7:0]  conv_r4,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned LAT_W = 3;
  localparam logic [CNT_W-1:0] FILL_LAST   = CNT_W'(4);
  localparam logic [CNT_W-1:0] OUT_LAST_M1 = CNT_W'(N_SAMPLES - 5);
  localparam logic [LAT_W-1:0] LAT_LAST    = LAT_W'(CONV_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_ISSUE, S_WAIT, S_OUT, S_STEP, S_DONE
  } state_t;

  state_t             state;
  logic [39:0]        win;
  logic [CNT_W-1:0]   in_cnt;
  logic [CNT_W-1:0]   out_cnt;
  logic [LAT_W-1:0]   lat_cnt;

  assign conv_win = win;

  // Single registered FSM; every output below is a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      win     <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      lat_cnt <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      s_ready <= 1'b0;
      conv_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FILL;
            win     <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_FILL: begin
          if (s_valid) begin
            win    <= {s_data, win[39:8]};
            in_cnt <= in_cnt + CNT_W'(1);
            if (in_cnt == FILL_LAST) begin
              state   <= S_ISSUE;
              s_ready <= 1'b0;
              conv_en <= 1'b1;
              lat_cnt <= '0;
            end
          end
        end
        // Window is frozen here because s_ready is low; capture on the last enable cycle.
        S_ISSUE, S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            m_data  <= {conv_r4, conv_r3, conv_r2, conv_r1};
            m_valid <= 1'b1;
            conv_en <= 1'b0;
            state   <= S_OUT;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
            state   <= S_WAIT;
          end
        end
        S_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            out_cnt <= out_cnt + CNT_W'(1);
            if (out_cnt == OUT_LAST_M1) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_STEP;
              s_ready <= 1'b1;
            end
          end
        end
        S_STEP: begin
          if (s_valid) begin
            win     <= {s_data, win[39:8]};
            in_cnt  <= in_cnt + CNT_W'(1);
            state   <= S_ISSUE;
            s_ready <= 1'b0;
            conv_en <= 1'b1;
            lat_cnt <= '0;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
